// File: rtl/sel_code_gen_pkg.sv
// Shared definitions for the select-code generator: FSM states, code width and
// the modulo-8 step helper.
package sel_code_gen_pkg;

  localparam int unsigned CODE_W = 3;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  // One step up or down; the natural 3-bit overflow provides the 7<->0 wrap.
  function automatic logic [CODE_W-1:0] code_step(input logic [CODE_W-1:0] code,
                                                   input logic              up);
    return up ? code + CODE_W'(1) : code - CODE_W'(1);
  endfunction

endpackage

// File: rtl/sel_code_gen_if.sv
// Button inputs and decoder-select outputs of the select-code generator.
//  master (generator): key_up/key_down/key_mode in; in1..in3, auto_en, code_chg out
//  slave  (panel/decoder side): the mirror image
interface sel_code_gen_if;
  logic key_up;
  logic key_down;
  logic key_mode;
  logic in1;
  logic in2;
  logic in3;
  logic auto_en;
  logic code_chg;

  modport master (
    input  key_up, key_down, key_mode,
    output in1, in2, in3, auto_en, code_chg
  );

  modport slave (
    output key_up, key_down, key_mode,
    input  in1, in2, in3, auto_en, code_chg
  );
endinterface

// File: rtl/sel_code_gen_key_filter.sv
// Debounce filter for one active-low push-button.
//  sys_clk, sys_rst_n : clock, async active-low reset
//  key_in             : raw button, active-low, asynchronous
//  key_flag           : one-cycle pulse once the key has been low CNT_MAX samples
module sel_code_gen_key_filter #(
  parameter int unsigned CNT_MAX = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag
);

  localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          done;

  // Synchroniser, saturating low-time counter and single-shot press flag.
  // done marks that the flag already fired for this press, so holding the key
  // at saturation produces no further flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync     <= 2'b11;
      cnt      <= '0;
      done     <= 1'b0;
      key_flag <= 1'b0;
    end else begin
      sync     <= {sync[0], key_in};
      key_flag <= 1'b0;
      if (sync[1]) begin
        cnt  <= '0;
        done <= 1'b0;
      end else if (cnt != CNT_TOP) begin
        cnt <= cnt + CW'(1);
      end else if (!done) begin
        done     <= 1'b1;
        key_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_code_gen.sv
// Select-code generator feeding a 3-to-8 decoder: debounced up/down/mode keys
// step a 3-bit code manually, or a timer steps it in AUTO mode.
//  sys_clk, sys_rst_n : clock, async active-low reset
//  bus (master)       : keys in; in1..in3 (code MSB..LSB), auto_en, code_chg out
module sel_code_gen
  import sel_code_gen_pkg::*;
#(
  parameter int unsigned CNT_DEBOUNCE = 1_000_000,
  parameter int unsigned CNT_STEP     = 25_000_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  sel_code_gen_if.master        bus
);

  localparam int unsigned TW = (CNT_STEP > 1) ? $clog2(CNT_STEP) : 1;
  localparam logic [TW-1:0] STEP_TOP = TW'(CNT_STEP - 1);

  logic              up_flag;
  logic              down_flag;
  logic              mode_flag;
  state_t            state;
  logic [TW-1:0]     timer;
  logic [CODE_W-1:0] code;
  logic              auto_en_q;
  logic              code_chg_q;

  sel_code_gen_key_filter #(.CNT_MAX(CNT_DEBOUNCE)) u_flt_up (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (bus.key_up),
    .key_flag (up_flag)
  );

  sel_code_gen_key_filter #(.CNT_MAX(CNT_DEBOUNCE)) u_flt_down (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (bus.key_down),
    .key_flag (down_flag)
  );

  sel_code_gen_key_filter #(.CNT_MAX(CNT_DEBOUNCE)) u_flt_mode (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (bus.key_mode),
    .key_flag (mode_flag)
  );

  // Mode FSM, step timer and code register. Priority: mode > up/down > timer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_MANUAL;
      timer      <= '0;
      code       <= '0;
      auto_en_q  <= 1'b0;
      code_chg_q <= 1'b0;
    end else begin
      code_chg_q <= 1'b0;
      case (state)
        ST_MANUAL: begin
          if (mode_flag) begin
            state     <= ST_AUTO;
            timer     <= '0;
            auto_en_q <= 1'b1;
          end else if (up_flag ^ down_flag) begin
            code       <= code_step(code, up_flag);
            code_chg_q <= 1'b1;
          end
        end
        ST_AUTO: begin
          if (mode_flag) begin
            state     <= ST_MANUAL;
            timer     <= '0;
            auto_en_q <= 1'b0;
          end else if (timer == STEP_TOP) begin
            timer      <= '0;
            code       <= code_step(code, 1'b1);
            code_chg_q <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= ST_MANUAL;
      endcase
    end
  end

  assign bus.in1      = code[2];
  assign bus.in2      = code[1];
  assign bus.in3      = code[0];
  assign bus.auto_en  = auto_en_q;
  assign bus.code_chg = code_chg_q;

endmodule

// File: tb/tb_sel_code_gen.sv
module tb_sel_code_gen;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   chg_cnt = 0;

  sel_code_gen_if bus ();

  sel_code_gen #(.CNT_DEBOUNCE(4), .CNT_STEP(10)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (bus.code_chg === 1'b1) chg_cnt <= chg_cnt + 1;

  function automatic logic [2:0] code_now();
    return {bus.in1, bus.in2, bus.in3};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // 0=up 1=down 2=mode
  task automatic set_key(input int k, input logic v);
    case (k)
      0: bus.key_up   = v;
      1: bus.key_down = v;
      default: bus.key_mode = v;
    endcase
  endtask

  task automatic press(input int k, input int low_cycles);
    @(negedge sys_clk);
    set_key(k, 1'b0);
    idle(low_cycles);
    set_key(k, 1'b1);
    idle(8);
  endtask

  task automatic wait_auto(input logic val, input int maxc, output int n);
    n = 0;
    while (bus.auto_en !== val && n < maxc) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic wait_chg(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (bus.code_chg !== 1'b1 && n < maxc);
  endtask

  task automatic test_reset();
    int base;
    bus.key_up = 1'b1; bus.key_down = 1'b1; bus.key_mode = 1'b1;
    sys_rst_n = 1'b0;
    idle(3);
    n_cmp++; if (code_now() !== 3'b000) begin n_err++; $display("FAIL rst_code got %b want 000", code_now()); end
    n_cmp++; if (bus.auto_en !== 1'b0) begin n_err++; $display("FAIL rst_auto got %b want 0", bus.auto_en); end
    n_cmp++; if (bus.code_chg !== 1'b0) begin n_err++; $display("FAIL rst_chg got %b want 0", bus.code_chg); end
    base = chg_cnt;
    sys_rst_n = 1'b1;
    idle(10);
    n_cmp++; if (code_now() !== 3'b000) begin n_err++; $display("FAIL post_rst_code got %b want 000", code_now()); end
    n_cmp++; if (bus.auto_en !== 1'b0) begin n_err++; $display("FAIL post_rst_auto got %b want 0", bus.auto_en); end
    n_cmp++; if (chg_cnt - base !== 0) begin n_err++; $display("FAIL post_rst_pulses got %0d want 0", chg_cnt - base); end
  endtask

  task automatic test_bounce();
    int base = chg_cnt;
    @(negedge sys_clk);
    bus.key_up = 1'b0; idle(3);
    bus.key_up = 1'b1; idle(1);
    bus.key_up = 1'b0; idle(2);
    bus.key_up = 1'b1; idle(10);
    n_cmp++; if (code_now() !== 3'b000) begin n_err++; $display("FAIL bounce_code got %b want 000", code_now()); end
    n_cmp++; if (chg_cnt - base !== 0) begin n_err++; $display("FAIL bounce_pulses got %0d want 0", chg_cnt - base); end
    base = chg_cnt;
    press(0, 20);
    n_cmp++; if (code_now() !== 3'b001) begin n_err++; $display("FAIL long_press_code got %b want 001", code_now()); end
    n_cmp++; if (chg_cnt - base !== 1) begin n_err++; $display("FAIL long_press_pulses got %0d want 1", chg_cnt - base); end
  endtask

  task automatic test_wrap();
    int base;
    press(1, 8);
    n_cmp++; if (code_now() !== 3'b000) begin n_err++; $display("FAIL down_to_0 got %b want 000", code_now()); end
    press(1, 8);
    n_cmp++; if (code_now() !== 3'b111) begin n_err++; $display("FAIL wrap_down got %b want 111", code_now()); end
    base = chg_cnt;
    for (int i = 0; i < 8; i++) press(0, 8);
    n_cmp++; if (code_now() !== 3'b111) begin n_err++; $display("FAIL wrap_up8 got %b want 111", code_now()); end
    n_cmp++; if (chg_cnt - base !== 8) begin n_err++; $display("FAIL wrap_up8_pulses got %0d want 8", chg_cnt - base); end
  endtask

  task automatic test_auto();
    int n;
    @(negedge sys_clk);
    bus.key_mode = 1'b0;
    wait_auto(1'b1, 30, n);
    bus.key_mode = 1'b1;
    n_cmp++; if (bus.auto_en !== 1'b1) begin n_err++; $display("FAIL auto_enter got %b want 1", bus.auto_en); end
    n_cmp++; if (code_now() !== 3'b111) begin n_err++; $display("FAIL auto_entry_code got %b want 111", code_now()); end
    wait_chg(30, n);
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL auto_first_step cycles %0d want 10", n); end
    n_cmp++; if (code_now() !== 3'b000) begin n_err++; $display("FAIL auto_wrap got %b want 000", code_now()); end
    bus.key_up = 1'b0;
    wait_chg(30, n);
    n_cmp++; if (n !== 10 || code_now() !== 3'b001) begin n_err++; $display("FAIL auto_step2 cycles %0d code %b want 10/001", n, code_now()); end
    wait_chg(30, n);
    bus.key_up = 1'b1;
    n_cmp++; if (n !== 10 || code_now() !== 3'b010) begin n_err++; $display("FAIL auto_up_ignored cycles %0d code %b want 10/010", n, code_now()); end
  endtask

  task automatic test_simul();
    int n, base;
    logic [2:0] c0;
    @(negedge sys_clk);
    bus.key_mode = 1'b0;
    wait_auto(1'b0, 30, n);
    bus.key_mode = 1'b1;
    n_cmp++; if (bus.auto_en !== 1'b0) begin n_err++; $display("FAIL auto_exit got %b want 0", bus.auto_en); end
    idle(12);
    c0 = code_now();
    base = chg_cnt;
    @(negedge sys_clk);
    bus.key_up = 1'b0; bus.key_down = 1'b0;
    idle(8);
    bus.key_up = 1'b1; bus.key_down = 1'b1;
    idle(8);
    n_cmp++; if (code_now() !== c0) begin n_err++; $display("FAIL updown_code got %b want %b", code_now(), c0); end
    n_cmp++; if (chg_cnt - base !== 0) begin n_err++; $display("FAIL updown_pulses got %0d want 0", chg_cnt - base); end
    @(negedge sys_clk);
    bus.key_up = 1'b0; bus.key_mode = 1'b0;
    wait_auto(1'b1, 30, n);
    n_cmp++; if (bus.auto_en !== 1'b1 || code_now() !== c0) begin n_err++; $display("FAIL mode_up auto %b code %b want 1/%b", bus.auto_en, code_now(), c0); end
    bus.key_up = 1'b1; bus.key_mode = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (code_now() !== 3'b101 && n < 100) begin @(negedge sys_clk); n++; end
    n_cmp++; if (code_now() !== 3'b101 || bus.auto_en !== 1'b1) begin n_err++; $display("FAIL reach_101 code %b auto %b want 101/1", code_now(), bus.auto_en); end
    bus.key_mode = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_cmp++; if (code_now() !== 3'b000 || bus.auto_en !== 1'b0 || bus.code_chg !== 1'b0) begin
      n_err++; $display("FAIL mid_rst code %b auto %b chg %b want 000/0/0", code_now(), bus.auto_en, bus.code_chg); end
    idle(3);
    sys_rst_n = 1'b1;
    idle(4);
    n_cmp++; if (bus.auto_en !== 1'b0) begin n_err++; $display("FAIL no_early_toggle got %b want 0", bus.auto_en); end
    wait_auto(1'b1, 20, n);
    n_cmp++; if (n + 4 !== 7) begin n_err++; $display("FAIL redebounce cycles %0d want 7", n + 4); end
    n_cmp++; if (code_now() !== 3'b000) begin n_err++; $display("FAIL redebounce_code got %b want 000", code_now()); end
    bus.key_mode = 1'b1;
    idle(4);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_wrap();
    test_auto();
    test_simul();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
